// File: rtl/reg_bus_pkg.sv
// Shared types and defaults for the tri-state register bus arbiter.
// The bus state encoding is kept to two bits so other bus sequencers can reuse it.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    TURN  = 2'd3
  } bus_state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_NDST = 8;

endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
// Shared with the other bus arbiters in the processor.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  // cand[gi] is the source index sitting gi places after the pointer.
  logic [PW-1:0] cand [N];
  logic [N-1:0]  rot;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [PW:0] sum;
    assign sum       = {1'b0, ptr} + (PW+1)'(gi);
    assign cand[gi]  = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];
    assign rot[gi]   = req[cand[gi]];
  end

  always_comb begin
    valid = |rot;
    idx   = '0;
    // Walk downward so the smallest offset from the pointer wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter and transfer sequencer for the shared tri-state register bus.
// Each transfer is GRANT (settle), XFER (strobe), TURN (bus released) so drivers never overlap.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int NDST = DEF_NDST,
  parameter int DW   = $clog2(NDST)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] dst,
  output logic [NREQ-1:0]    oe,
  output logic [NDST-1:0]    write_ctrl,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic               busy
);

  localparam int GW = $clog2(NREQ);

  bus_state_t    state_reg, state_next;
  logic [GW-1:0] ptr_reg, ptr_next;
  logic [GW-1:0] g_reg, g_next;
  logic [DW-1:0] dst_reg, dst_next;

  logic [NREQ-1:0] oe_next;
  logic [NDST-1:0] wc_next;
  logic [NREQ-1:0] ack_next;
  logic            err_next;
  logic            busy_next;

  logic          pick_valid;
  logic [GW-1:0] pick_idx;
  logic [DW-1:0] dst_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_dst
    assign dst_arr[gi] = dst[gi*DW +: DW];
  end

  rr_pick #(
    .N  (NREQ),
    .PW (GW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state: arbitrate only when the bus is free (IDLE or TURN).
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    g_next     = g_reg;
    dst_next   = dst_reg;
    case (state_reg)
      IDLE, TURN: begin
        if (pick_valid) begin
          state_next = GRANT;
          g_next     = pick_idx;
          dst_next   = dst_arr[pick_idx];
          ptr_next   = (pick_idx == GW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT:   state_next = XFER;
      XFER:    state_next = TURN;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with the state they describe.
  always_comb begin
    oe_next   = '0;
    wc_next   = '0;
    ack_next  = '0;
    err_next  = 1'b0;
    busy_next = (state_next != IDLE);
    if (state_next == GRANT || state_next == XFER) begin
      oe_next[g_next] = 1'b1;
    end
    if (state_next == XFER) begin
      ack_next[g_next] = 1'b1;
      if ({1'b0, dst_next} < (DW+1)'(NDST)) begin
        wc_next[dst_next] = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      g_reg      <= '0;
      dst_reg    <= '0;
      oe         <= '0;
      write_ctrl <= '0;
      ack        <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      g_reg      <= g_next;
      dst_reg    <= dst_next;
      oe         <= oe_next;
      write_ctrl <= wc_next;
      ack        <= ack_next;
      err        <= err_next;
      busy       <= busy_next;
    end
  end

endmodule
